// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Receive-side PRBS checker. A local Galois LFSR is first seeded from the
// incoming stream (checker mode: received bits are fed back). After
// LOCK_COUNT consecutive error-free beats the checker declares lock. From then
// on the LFSR free-runs (generator mode) so that a flipped received bit shows
// up as exactly one error and does not propagate. In LOCKED, errored beats
// are counted inside a sliding LOSS_WINDOW of valid beats. LOSS_THRESHOLD
// errored beats in one window drop the checker back to SEARCH.
//
// POLYNOMIAL encoding: bit k-1 set means tap x^k is present (taps
// [POLY_DEGREE:1]). The default value 7'h60 is PRBS7 (x^7 + x^6 + 1).
// DATA_WIDTH bits form one beat; bit 0 is the earliest bit in time.
//
// Ports:
//   aclk          clock
//   aresetn       asynchronous active-low reset
//   s_tvalid      beat valid (no backpressure)
//   s_tdata       received PRBS data
//   cnt_clr       synchronous clear of err_cnt and lock_loss_cnt
//   rx_invert     (PRBS_CHK_INVERT_EN only) invert received data before checking
//   locked        checker is in the LOCKED state
//   err_pulse     one-cycle pulse per errored beat seen while LOCKED
//   err_cnt       saturating count of bit errors seen while LOCKED
//   lock_loss_cnt saturating count of LOCKED->SEARCH transitions
//
// Optional feature macro: PRBS_CHK_INVERT_EN (adds the rx_invert port).
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int                     POLY_DEGREE    = 7,
    parameter logic [POLY_DEGREE-1:0] POLYNOMIAL     = 7'h60,
    parameter int                     DATA_WIDTH     = 8,
    parameter int                     LOCK_COUNT     = 16,
    parameter int                     LOSS_WINDOW    = 64,
    parameter int                     LOSS_THRESHOLD = 4,
    parameter int                     CNT_WIDTH      = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  cnt_clr,
`ifdef PRBS_CHK_INVERT_EN
    input  logic                  rx_invert,
`endif
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  lock_loss_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int BAD_W  = $clog2(LOSS_THRESHOLD + 1);
    localparam int POP_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Galois LFSR step over one beat. Returns {next_state, data_out} where
    // data_out is the per-bit mismatch between data_in and the prediction.
    // chk_not_gen=1 feeds the received bit back (self-synchronising seed);
    // chk_not_gen=0 feeds the predicted bit back (free-running generator).
    function automatic logic [POLY_DEGREE+DATA_WIDTH-1:0] lfsr_galois(
        input logic [POLY_DEGREE-1:0] state_in,
        input logic [DATA_WIDTH-1:0]  data_in,
        input logic                   chk_not_gen
    );
        logic [POLY_DEGREE-1:0] st;
        logic [DATA_WIDTH-1:0]  data_out;
        logic                   pred;
        logic                   fb;
        st       = state_in;
        data_out = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pred        = st[0];
            data_out[i] = data_in[i] ^ pred;
            fb          = chk_not_gen ? data_in[i] : pred;
            st          = {1'b0, st[POLY_DEGREE-1:1]} ^ (fb ? POLYNOMIAL : '0);
        end
        return {st, data_out};
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [POP_W-1:0]     b
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    state_t                  state_p1, state_nxt;
    logic [POLY_DEGREE-1:0]  lfsr_p1, lfsr_nxt;
    logic [GOOD_W-1:0]       good_cnt_p1, good_cnt_nxt;
    logic [WIN_W-1:0]        win_cnt_p1, win_cnt_nxt;
    logic [BAD_W-1:0]        bad_cnt_p1, bad_cnt_nxt;
    logic                    err_pulse_p1, err_pulse_nxt;
    logic [CNT_WIDTH-1:0]    err_cnt_p1, err_cnt_nxt;
    logic [CNT_WIDTH-1:0]    loss_cnt_p1, loss_cnt_nxt;

    logic [DATA_WIDTH-1:0]   data_p0;
    logic [POLY_DEGREE+DATA_WIDTH-1:0] step_p0;
    logic [DATA_WIDTH-1:0]   err_vec_p0;
    logic [POLY_DEGREE-1:0]  lfsr_step_p0;
    logic                    beat_err_p0;
    logic [BAD_W-1:0]        bad_inc_p0;

    // Stage p0: compare the received beat against the local sequence
`ifdef PRBS_CHK_INVERT_EN
    assign data_p0 = s_tdata ^ {DATA_WIDTH{rx_invert}};
`else
    assign data_p0 = s_tdata;
`endif

    assign step_p0      = lfsr_galois(lfsr_p1, data_p0, state_p1 == SEARCH);
    assign err_vec_p0   = step_p0[DATA_WIDTH-1:0];
    assign lfsr_step_p0 = step_p0[POLY_DEGREE+DATA_WIDTH-1:DATA_WIDTH];
    assign beat_err_p0  = |err_vec_p0;
    assign bad_inc_p0   = bad_cnt_p1 + BAD_W'(beat_err_p0);

    always_comb begin
        state_nxt     = state_p1;
        lfsr_nxt      = lfsr_p1;
        good_cnt_nxt  = good_cnt_p1;
        win_cnt_nxt   = win_cnt_p1;
        bad_cnt_nxt   = bad_cnt_p1;
        err_pulse_nxt = 1'b0;
        err_cnt_nxt   = err_cnt_p1;
        loss_cnt_nxt  = loss_cnt_p1;

        if (s_tvalid) begin
            lfsr_nxt = lfsr_step_p0;
            unique case (state_p1)
                SEARCH: begin
                    if (beat_err_p0) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt_p1 == GOOD_W'(LOCK_COUNT - 1)) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                        win_cnt_nxt  = '0;
                        bad_cnt_nxt  = '0;
                    end else begin
                        good_cnt_nxt = good_cnt_p1 + 1'b1;
                    end
                end
                LOCKED: begin
                    err_pulse_nxt = beat_err_p0;
                    err_cnt_nxt   = sat_add(err_cnt_p1, popcount(err_vec_p0));
                    // Threshold is tested before the window wrap so an
                    // errored last beat of a window still counts.
                    if (bad_inc_p0 == BAD_W'(LOSS_THRESHOLD)) begin
                        state_nxt    = SEARCH;
                        good_cnt_nxt = '0;
                        win_cnt_nxt  = '0;
                        bad_cnt_nxt  = '0;
                        loss_cnt_nxt = sat_add(loss_cnt_p1, POP_W'(1));
                    end else if (win_cnt_p1 == WIN_W'(LOSS_WINDOW - 1)) begin
                        win_cnt_nxt = '0;
                        bad_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt = win_cnt_p1 + 1'b1;
                        bad_cnt_nxt = bad_inc_p0;
                    end
                end
                default: ;
            endcase
        end

        if (cnt_clr) begin
            err_cnt_nxt  = '0;
            loss_cnt_nxt = '0;
        end
    end

    // Stage p1: registered state and status
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_p1     <= SEARCH;
            lfsr_p1      <= '1;
            good_cnt_p1  <= '0;
            win_cnt_p1   <= '0;
            bad_cnt_p1   <= '0;
            err_pulse_p1 <= 1'b0;
            err_cnt_p1   <= '0;
            loss_cnt_p1  <= '0;
        end else begin
            state_p1     <= state_nxt;
            lfsr_p1      <= lfsr_nxt;
            good_cnt_p1  <= good_cnt_nxt;
            win_cnt_p1   <= win_cnt_nxt;
            bad_cnt_p1   <= bad_cnt_nxt;
            err_pulse_p1 <= err_pulse_nxt;
            err_cnt_p1   <= err_cnt_nxt;
            loss_cnt_p1  <= loss_cnt_nxt;
        end
    end

    assign locked        = (state_p1 == LOCKED);
    assign err_pulse     = err_pulse_p1;
    assign err_cnt       = err_cnt_p1;
    assign lock_loss_cnt = loss_cnt_p1;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
//
// Drives a PRBS7 stream (s[n] = s[n-6] ^ s[n-7]) into prbs_checker with
// deliberate bit flips, random valid gaps and counter clears. A reference
// model tracks the checker's expected behaviour using a short history of bits
// and the recurrence, plus plain integer counters for lock/loss rules.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int LOCK_COUNT     = 16;
    localparam int LOSS_WINDOW    = 64;
    localparam int LOSS_THRESHOLD = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        cnt_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [31:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    prbs_checker dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .cnt_clr       (cnt_clr),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Transmitter history: last 7 sent bits, oldest first.
    bit tx_hist[$];

    // Reference model state. m_hist is the 7-bit history the checker
    // predicts from (oldest first): received bits while searching, its own
    // predictions while locked.
    bit m_hist[$];
    int m_locked, m_good, m_win, m_bad, m_err, m_loss, m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic seed_tx();
        logic [6:0] s;
        s = 7'($urandom_range(1, 127));
        tx_hist = {};
        for (int i = 0; i < 7; i++) tx_hist.push_back(s[i]);
    endtask

    task automatic gen_beat(output logic [7:0] b);
        bit nb;
        for (int j = 0; j < 8; j++) begin
            nb   = tx_hist[0] ^ tx_hist[1];
            b[j] = nb;
            tx_hist.push_back(nb);
            void'(tx_hist.pop_front());
        end
    endtask

    // An all-ones LFSR register predicts the same bits as this history.
    task automatic model_reset();
        m_hist   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        m_locked = 0; m_good = 0; m_win = 0; m_bad = 0;
        m_err    = 0; m_loss = 0; m_pulse = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        int errs;
        bit pred;
        m_pulse = 0;
        errs    = 0;
        if (v) begin
            for (int j = 0; j < 8; j++) begin
                pred = m_hist[0] ^ m_hist[1];
                if (d[j] != pred) errs++;
                m_hist.push_back(m_locked != 0 ? pred : d[j]);
                void'(m_hist.pop_front());
            end
            if (m_locked == 0) begin
                if (errs == 0) m_good++;
                else m_good = 0;
                if (m_good == LOCK_COUNT) begin
                    m_locked = 1; m_good = 0; m_win = 0; m_bad = 0;
                end
            end else begin
                m_err  += errs;
                m_pulse = (errs > 0) ? 1 : 0;
                if (errs > 0) m_bad++;
                if (m_bad >= LOSS_THRESHOLD) begin
                    m_locked = 0; m_good = 0; m_win = 0; m_bad = 0;
                    m_loss++;
                end else begin
                    m_win++;
                    if (m_win == LOSS_WINDOW) begin
                        m_win = 0; m_bad = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_err  = 0;
            m_loss = 0;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
        s_tvalid = v;
        s_tdata  = d;
        cnt_clr  = clr;
        @(posedge aclk);
        model_step(v, d, clr);
        @(negedge aclk);
        s_tvalid = 1'b0;
        cnt_clr  = 1'b0;
        check("locked", 32'(locked), m_locked);
        check("err_pulse", 32'(err_pulse), m_pulse);
        check("err_cnt", err_cnt, m_err);
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
    endtask

    task automatic clean_beats(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            gen_beat(b);
            cycle(1'b1, b, 1'b0);
        end
    endtask

    task automatic err_beat(input logic [7:0] mask, input logic clr);
        logic [7:0] b;
        gen_beat(b);
        cycle(1'b1, b ^ mask, clr);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        cnt_clr  = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_lock_loss_cnt", lock_loss_cnt, 0);
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic wait_lock(input string tag);
        int n;
        n = 0;
        while (m_locked == 0 && n < 200) begin
            clean_beats(1);
            n++;
        end
        check(tag, 32'(locked), 1);
    endtask

    // Leaves the model at the first beat of a fresh loss window.
    task automatic align_window();
        int n;
        n = 0;
        do begin
            clean_beats(1);
            n++;
        end while (m_win != 0 && n < LOSS_WINDOW);
    endtask

    task automatic random_phase(input int ncyc, input bit inject);
        logic [7:0] b;
        logic       v;
        logic       clr;
        for (int i = 0; i < ncyc; i++) begin
            v   = 1'($urandom_range(0, 1));
            clr = inject && ($urandom_range(0, 31) == 0);
            if (v) begin
                gen_beat(b);
                if (inject && $urandom_range(0, 15) == 0)
                    b = b ^ (8'h01 << $urandom_range(0, 7));
            end else begin
                b = 8'($urandom);
            end
            cycle(v, b, clr);
        end
    endtask

    initial begin
        logic [7:0] mask;
        int         nvalid;
        int         ncyc;
        logic [7:0] b;
        logic       v;

        seed_tx();
        model_reset();
        @(negedge aclk);
        do_reset();

        // Clean continuous stream: lock by beat 17, then no errors.
        clean_beats(17);
        check("lock_by_17", 32'(locked), 1);
        clean_beats(1000);
        check("clean_err_cnt", err_cnt, 0);

        // Single and double bit flips while locked.
        err_beat(8'h08, 1'b0);
        check("flip1_pulse", 32'(err_pulse), 1);
        check("flip1_err_cnt", err_cnt, 1);
        check("flip1_locked", 32'(locked), 1);
        clean_beats(1);
        check("flip1_pulse_drop", 32'(err_pulse), 0);
        err_beat(8'h41, 1'b0);
        check("flip2_err_cnt", err_cnt, 3);

        // Four errored beats inside one window force loss of lock.
        align_window();
        for (int i = 0; i <= 30; i++) begin
            if (i % 10 == 0) err_beat(8'h01 << (i / 10), 1'b0);
            else clean_beats(1);
            if (i == 20) check("loss_pre_locked", 32'(locked), 1);
        end
        check("loss_locked", 32'(locked), 0);
        check("loss_cnt", lock_loss_cnt, 1);
        check("loss_err_cnt", err_cnt, 7);
        clean_beats(15);
        check("relock_15", 32'(locked), 0);
        clean_beats(1);
        check("relock_16", 32'(locked), 1);

        // Three errored beats in each of two consecutive windows.
        align_window();
        for (int i = 0; i < 128; i++) begin
            case (i)
                5:       mask = 8'h01;
                20:      mask = 8'h06;
                40:      mask = 8'h80;
                66:      mask = 8'h10;
                94:      mask = 8'h38;
                124:     mask = 8'h02;
                default: mask = 8'h00;
            endcase
            err_beat(mask, 1'b0);
        end
        check("win_locked", 32'(locked), 1);
        check("win_err_cnt", err_cnt, 16);
        check("win_loss_cnt", lock_loss_cnt, 1);

        // Random valid gaps on a clean stream after reset.
        do_reset();
        nvalid = 0;
        ncyc   = 0;
        while (nvalid < 17 && ncyc < 400) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                gen_beat(b);
                nvalid++;
            end else begin
                b = 8'($urandom);
            end
            cycle(v, b, 1'b0);
            ncyc++;
        end
        check("gap_lock", 32'(locked), 1);
        check("gap_err_cnt", err_cnt, 0);

        // Random gaps, sporadic bit flips and clears.
        random_phase(600, 1'b1);

        // Clear in the same cycle as an errored locked beat.
        wait_lock("clr_relock");
        align_window();
        err_beat(8'h04, 1'b1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_loss_cnt", lock_loss_cnt, 0);
        check("clr_pulse", 32'(err_pulse), 1);
        check("clr_locked", 32'(locked), 1);

        // Reset while locked with a nonzero error count.
        err_beat(8'h20, 1'b0);
        check("pre_rst_err_cnt", err_cnt, 1);
        do_reset();
        clean_beats(17);
        check("post_rst_lock", 32'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side PRBS checker; the counterpart to the LFSR-based PRBS generator.
- Takes a parallel PRBS stream, self-synchronises its local Galois LFSR to the stream, declares lock, then counts bit errors against a free-running local sequence.
- Sits at the sink of link/loopback test paths and feeds status and counters to CSR logic.
- Reuses the lfsr_galois step function: checker mode (CHK_NOT_GEN=1) for seeding, generator mode (CHK_NOT_GEN=0) once locked.

Parameters:
- POLY_DEGREE, 7, LFSR degree.
- POLYNOMIAL, PRBS7 (lfsr_pkg), feedback taps [POLY_DEGREE:1].
- DATA_WIDTH, 8, bits per beat; bit 0 is the earliest bit in time.
- LOCK_COUNT, 16, consecutive error-free beats needed to lock (>=1).
- LOSS_WINDOW, 64, locked-mode observation window in valid beats.
- LOSS_THRESHOLD, 4, errored beats within one window that force loss of lock.
- CNT_WIDTH, 32, width of the error and lock-loss counters.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_tvalid, in, 1, input beat valid; no backpressure, beat consumed whenever high.
- s_tdata, in, DATA_WIDTH, received PRBS data.
- cnt_clr, in, 1, synchronous clear of err_cnt and lock_loss_cnt.
- locked, out, 1, checker is in LOCKED state.
- err_pulse, out, 1, one-cycle pulse for each errored beat while LOCKED.
- err_cnt, out, CNT_WIDTH, saturating count of bit errors seen while LOCKED.
- lock_loss_cnt, out, CNT_WIDTH, saturating count of LOCKED->SEARCH transitions.

Behaviour:
- Reset (async assert, sync deassert handled upstream). All registers are cleared:
  - state=SEARCH, LFSR state=all-ones, good_cnt=0, win_cnt=0, bad_cnt=0.
  - locked=0, err_pulse=0, err_cnt=0, lock_loss_cnt=0.
- Per valid beat, compute err_vec = lfsr_galois.data_out with data_in=s_tdata. Nonzero err_vec means the beat is errored.
- In SEARCH, the step uses CHK_NOT_GEN=1.
- In LOCKED, the step uses CHK_NOT_GEN=0.
- The LFSR state register updates only on s_tvalid=1. With s_tvalid=0, all state and counters hold.
- SEARCH:
  - Clean beat: good_cnt++. Errored beat: good_cnt=0.
  - When the beat making good_cnt reach LOCK_COUNT is accepted, go to LOCKED.
  - locked=1 from the next cycle; win_cnt=0 and bad_cnt=0.
- LOCKED:
  - err_cnt += popcount(err_vec), saturating at all-ones.
  - err_pulse=1 the cycle after an errored beat.
  - win_cnt counts valid beats 0..LOSS_WINDOW-1. On wrap, bad_cnt=0.
  - Errored beat: bad_cnt++.
  - If bad_cnt reaches LOSS_THRESHOLD (including on the current beat), go to SEARCH, good_cnt=0, lock_loss_cnt++ (saturating), locked=0 from the next cycle.
  - The errored beat that causes loss still adds to err_cnt.
- Error accounting:
  - Only errors observed in LOCKED are counted in err_cnt.
  - Locked mode is error non-propagating: one flipped bit adds exactly 1 to err_cnt.
- cnt_clr:
  - Clears err_cnt and lock_loss_cnt.
  - Has priority over a same-cycle increment; that beat's contribution is discarded.
  - Does not affect lock state.
- Latency: s_tdata to err_pulse, err_cnt, and lock-status update is 1 cycle.
- Reset asserted mid-operation returns to SEARCH immediately with all outputs 0.

Optional Feature:
- PRBS_CHK_INVERT_EN defined:
  - Adds input port rx_invert (1 bit, quasi-static).
  - When 1, s_tdata is bitwise inverted before the LFSR step, to check inverted-polarity links.
  - Lock and count behaviour is otherwise unchanged.
- PRBS_CHK_INVERT_EN undefined:
  - Port absent; data is used as received.

Test Plan:
- Clean PRBS7 stream, DATA_WIDTH=8, arbitrary generator seed, continuous valid:
  - locked=1 no later than the cycle after beat 17.
  - err_cnt stays 0 for 1000 further beats.
- Locked; flip bit 3 of one beat:
  - err_pulse high exactly one cycle, err_cnt=1, locked stays 1.
  - Flip 2 bits in another beat: err_cnt=3.
- Locked; corrupt 4 beats within 64 valid beats:
  - After the 4th, locked=0 next cycle and lock_loss_cnt=1.
  - Clean data then relocks after 16 clean beats.
- Locked; corrupt 3 beats in window 1 and 3 in window 2: no loss of lock, err_cnt equals total flipped bits.
- Random s_tvalid gaps (50% duty) on a clean stream: lock achieved after 16 clean valid beats, err_cnt=0.
- Counter clear and reset:
  - cnt_clr in the same cycle as an errored locked beat: err_cnt=0 next cycle.
  - aresetn pulsed while locked: locked, err_pulse, err_cnt, lock_loss_cnt all 0 during reset.
